// File: rtl/pc_pkg.sv
// pc_pkg: shared state/source encodings and constants for the PC sequencer.
package pc_pkg;
    typedef enum logic [1:0] {PC_RUN, PC_HALT, PC_FAULT} pc_state_e;
    typedef enum logic [1:0] {SRC_SEQ, SRC_BR, SRC_JAL, SRC_JALR} pc_src_e;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: control-side requests into the PC sequencer and its status/PC outputs.
interface pc_seq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic            stall_i;
    logic            branch_i;
    logic            jal_i;
    logic            jalr_i;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] rs1_i;
    logic            halt_i;
    logic            resume_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            fault_o;
    logic [XLEN-1:0] bad_tgt_o;
    logic            halted_o;
    logic [CNT_W-1:0] instret_o;
    modport master (
        output stall_i, branch_i, jal_i, jalr_i, imm_i, rs1_i, halt_i, resume_i,
        input  pc_o, pc_plus4_o, fault_o, bad_tgt_o, halted_o, instret_o
    );
    modport slave (
        input  stall_i, branch_i, jal_i, jalr_i, imm_i, rs1_i, halt_i, resume_i,
        output pc_o, pc_plus4_o, fault_o, bad_tgt_o, halted_o, instret_o
    );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc: prioritised next-PC target and misaligned-redirect detection.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] tgt,
    output logic            misalign
);
    pc_src_e src;
    always_comb begin
        src = jalr ? SRC_JALR : jal ? SRC_JAL : branch ? SRC_BR : SRC_SEQ;
        tgt = src == SRC_JALR ? (rs1 + imm) & ~XLEN'(1) :
              src == SRC_SEQ  ? pc + XLEN'(INSTR_BYTES) : pc + imm;
        // sequential steps are always aligned, so only redirects can fault
        misalign = src != SRC_SEQ && (tgt & XLEN'(IALIGN - 1)) != '0;
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with run/halt/fault control and retired-instruction count.
module pc_seq
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
    parameter int              IALIGN    = 4,
    parameter int              CNT_W     = 32
) (
    input logic       clk,
    input logic       rst_n,
    pc_seq_if.slave   bus
);
    pc_state_e        state;
    logic [XLEN-1:0]  pc, bad_tgt, tgt;
    logic [CNT_W-1:0] instret;
    logic             misalign;
    pc_target_calc #(.XLEN(XLEN), .IALIGN(IALIGN)) u_calc (
        .pc(pc), .imm(bus.imm_i), .rs1(bus.rs1_i),
        .branch(bus.branch_i), .jal(bus.jal_i), .jalr(bus.jalr_i),
        .tgt(tgt), .misalign(misalign)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PC_RUN;
            pc      <= RESET_VEC;
            bad_tgt <= '0;
            instret <= '0;
        end else begin
            case (state)
                PC_RUN: if (!bus.stall_i) begin
                    // a halting instruction retires; a faulting one does not
                    if (bus.halt_i) begin
                        state   <= PC_HALT;
                        instret <= instret + CNT_W'(1);
                    end else if (misalign) begin
                        state   <= PC_FAULT;
                        bad_tgt <= tgt;
                    end else begin
                        pc      <= tgt;
                        instret <= instret + CNT_W'(1);
                    end
                end
                PC_HALT: if (bus.resume_i) begin
                    state <= PC_RUN;
                    pc    <= pc + XLEN'(INSTR_BYTES);
                end
                PC_FAULT: if (bus.resume_i) begin
                    state <= PC_RUN;
                    pc    <= TRAP_VEC;
                end
                default: state <= PC_RUN;
            endcase
        end
    end
    assign bus.pc_o       = pc;
    assign bus.pc_plus4_o = pc + XLEN'(INSTR_BYTES);
    assign bus.fault_o    = state == PC_FAULT;
    assign bus.halted_o   = state == PC_HALT;
    assign bus.bad_tgt_o  = bad_tgt;
    assign bus.instret_o  = instret;
endmodule
